irq_controller: RTL
===================

# irq_controller

Peribus interrupt controller that collects peripheral interrupt lines (timer `irq` and siblings), latches them as pending, masks and prioritises them, and presents a single request plus source ID to the CPU. It sits directly downstream of the timer and the other Peribus peripherals, and directly upstream of the CPU interrupt entry logic. Software configures and services it through the standard Peribus register port.

## Interface
- `NUM_SOURCES`, 8, number of interrupt inputs (1..16)
- `ID_WIDTH`, 4, width of source ID
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  2  register select
- `write_data`  in  16  bus write data
- `write_en`  in  1  bus write strobe
- `read_en`  in  1  bus read strobe
- `chipselect`  in  1  block select; qualifies `write_en`/`read_en`
- `read_data`  out  16  registered read data
- `irq_in`  in  NUM_SOURCES  peripheral interrupt lines, level, asynchronous to nothing (same clock)
- `cpu_irq`  out  1  interrupt request to CPU
- `cpu_irq_id`  out  ID_WIDTH  source index of current request
- `cpu_irq_ack`  in  1  single-cycle CPU acknowledge (ISR entry)

## Operation
- Register map: 0 PENDING (R, write-1-to-clear); 1 ENABLE (R/W); 2 VECTOR (R: {active[15], in_service[14], 10'h0, id[3:0]}; writes ignored); 3 EOI (W any value = end of interrupt; R returns {15'h0, in_service}).
- Unused upper bits of PENDING/ENABLE read 0, writes ignored.
- Edge capture: `sync_q <= irq_in`; `prev_q <= sync_q`; rise = `sync_q & ~prev_q` sets PENDING bit. Same-cycle rise and W1C clear on same bit: set wins.
- Eligible = PENDING & ENABLE. Priority: lowest index wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible nonzero -> REQ, latch winning index into `cur_id`.
  - REQ: `cpu_irq`=1, `cpu_irq_id`=`cur_id`. On `cpu_irq_ack`: clear PENDING[`cur_id`], -> SERVICE. If eligible[`cur_id`] drops (W1C or ENABLE clear) without ack: -> IDLE (request withdrawn). ID does not change while in REQ even if a higher-priority source arrives.
  - SERVICE: `cpu_irq`=0; new sources keep pending. EOI write -> IDLE. EOI in IDLE/REQ ignored. `cpu_irq_ack` outside REQ ignored.
- No nesting.

## Timing
- Reset values: `read_data`=0, `cpu_irq`=0, `cpu_irq_id`=0, PENDING=0, ENABLE=0, `sync_q`=`prev_q`=0, state IDLE. A line held high through reset deassertion is captured as an edge.
- Reads: `read_data` updated on the edge where `chipselect && read_en`; valid next cycle; held otherwise.
- Writes take effect on the strobing edge.
- Latency: `irq_in` rises before edge 1 -> `sync_q` edge 1 -> PENDING edge 2 -> REQ and `cpu_irq`=1 after edge 3.
- Ack at edge k: `cpu_irq` low after edge k; PENDING bit cleared same edge.
- Next request earliest one cycle after EOI edge.
- Mid-operation `reset`: all state returns to reset values on that edge regardless of FSM state.

## Structure
- Package `irq_ctrl_pkg`: address constants (ADDR_PENDING..ADDR_EOI), VECTOR field offsets, `irq_state_t` enum {IDLE, REQ, SERVICE}.
- Sub-module `irq_priority_encoder`: combinational, NUM_SOURCES-bit vector in -> `valid` and lowest-set index out.

## Test plan
- Reset with `irq_in`=0 -> all outputs 0; read addr 1 returns 16'h0000.
- ENABLE=16'h0004, pulse `irq_in[2]` -> `cpu_irq`=1 three edges later, `cpu_irq_id`=2; ack -> `cpu_irq`=0, PENDING reads 0, VECTOR reads 16'h4002; EOI -> VECTOR 16'h0000.
- ENABLE=16'h00FF, `irq_in[5]` and `irq_in[1]` rise same cycle -> id 1 first; ack+EOI -> id 5 next.
- `irq_in[3]` rises with ENABLE=0 -> no `cpu_irq`, PENDING=16'h0008; write ENABLE=16'h0008 -> `cpu_irq` after one edge.
- In REQ for id 0, write PENDING=16'h0001 (W1C) -> `cpu_irq` deasserts, state IDLE; W1C coincident with new rise on bit 0 -> bit stays set.
- Assert `reset` during SERVICE -> next cycle state IDLE, PENDING/ENABLE=0, EOI write then has no effect.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the Peribus interrupt controller:
// register addresses, VECTOR register field layout and FSM states.
package irq_ctrl_pkg;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_VECTOR  = 2'd2;
    localparam logic [1:0] ADDR_EOI     = 2'd3;

    localparam int VEC_ACTIVE_BIT     = 15;
    localparam int VEC_IN_SERVICE_BIT = 14;
    localparam int VEC_ID_LSB         = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder: reports whether any request bit
// is set and the index of the lowest set bit (lowest index wins).
module irq_priority_encoder #(
    parameter int NUM_SOURCES = 8,
    parameter int ID_WIDTH    = 4
) (
    input  logic [NUM_SOURCES-1:0] req,
    output logic                   valid,
    output logic [ID_WIDTH-1:0]    index
);

    // Scan from the top down so the lowest set bit is the last to overwrite index.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Peribus interrupt controller: captures rising edges of peripheral lines
// into PENDING, masks them with ENABLE, and raises a single prioritised
// request to the CPU, tracking it through request and service phases.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int ID_WIDTH    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             addr,
    input  logic [15:0]            write_data,
    input  logic                   write_en,
    input  logic                   read_en,
    input  logic                   chipselect,
    output logic [15:0]            read_data,
    input  logic [NUM_SOURCES-1:0] irq_in,
    output logic                   cpu_irq,
    output logic [ID_WIDTH-1:0]    cpu_irq_id,
    input  logic                   cpu_irq_ack
);

    logic [NUM_SOURCES-1:0] sync_q;
    logic [NUM_SOURCES-1:0] prev_q;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] enable;
    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] cur_mask;
    logic [NUM_SOURCES-1:0] ack_clear;
    logic [NUM_SOURCES-1:0] w1c_mask;
    logic [ID_WIDTH-1:0]    cur_id;
    logic [ID_WIDTH-1:0]    next_id;
    logic [ID_WIDTH-1:0]    win_id;
    logic                   win_valid;
    logic                   cur_eligible;
    logic                   bus_write;
    logic                   bus_read;
    logic                   eoi_write;
    logic                   unused_write_bits;
    logic [15:0]            pending_word;
    logic [15:0]            enable_word;
    logic [15:0]            vector_word;
    logic [15:0]            read_word;
    irq_state_t             state;
    irq_state_t             next_state;

    assign bus_write         = chipselect && write_en;
    assign bus_read          = chipselect && read_en;
    assign eoi_write         = bus_write && (addr == ADDR_EOI);
    assign w1c_mask          = (bus_write && (addr == ADDR_PENDING)) ? write_data[NUM_SOURCES-1:0] : '0;
    assign unused_write_bits = ^write_data;

    assign rise         = sync_q & ~prev_q;
    assign eligible     = pending & enable;
    assign cur_mask     = NUM_SOURCES'(1) << cur_id;
    assign cur_eligible = |(eligible & cur_mask);

    assign cpu_irq    = (state == REQ);
    assign cpu_irq_id = cur_id;

    irq_priority_encoder #(
        .NUM_SOURCES (NUM_SOURCES),
        .ID_WIDTH    (ID_WIDTH)
    ) u_priority (
        .req   (eligible),
        .valid (win_valid),
        .index (win_id)
    );

    // Two-stage edge detector on the raw lines; a line already high at reset release reads as a rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= irq_in;
            prev_q <= sync_q;
        end
    end

    // PENDING and ENABLE registers; a new rise beats a same-cycle W1C or ack clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            enable  <= '0;
        end else begin
            pending <= (pending & ~w1c_mask & ~ack_clear) | rise;
            if (bus_write && (addr == ADDR_ENABLE)) begin
                enable <= write_data[NUM_SOURCES-1:0];
            end
        end
    end

    // FSM state and latched request ID.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cur_id <= '0;
        end else begin
            state  <= next_state;
            cur_id <= next_id;
        end
    end

    // Next-state logic: the ID is frozen once a request is raised and cleared when returning to IDLE.
    always_comb begin
        next_state = state;
        next_id    = cur_id;
        ack_clear  = '0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    next_state = REQ;
                    next_id    = win_id;
                end
            end
            REQ: begin
                if (cpu_irq_ack) begin
                    next_state = SERVICE;
                    ack_clear  = cur_mask;
                end else if (!cur_eligible) begin
                    next_state = IDLE;
                    next_id    = '0;
                end
            end
            SERVICE: begin
                if (eoi_write) begin
                    next_state = IDLE;
                    next_id    = '0;
                end
            end
            default: begin
                next_state = IDLE;
                next_id    = '0;
            end
        endcase
    end

    // Assemble the register views and select the one addressed for reading.
    always_comb begin
        pending_word                      = '0;
        enable_word                       = '0;
        vector_word                       = '0;
        pending_word[NUM_SOURCES-1:0]     = pending;
        enable_word[NUM_SOURCES-1:0]      = enable;
        vector_word[VEC_ACTIVE_BIT]       = (state == REQ);
        vector_word[VEC_IN_SERVICE_BIT]   = (state == SERVICE);
        vector_word[VEC_ID_LSB +: ID_WIDTH] = cur_id;
        case (addr)
            ADDR_PENDING: read_word = pending_word;
            ADDR_ENABLE:  read_word = enable_word;
            ADDR_VECTOR:  read_word = vector_word;
            default:      read_word = {15'h0, (state == SERVICE)};
        endcase
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data <= '0;
        end else if (bus_read) begin
            read_data <= read_word;
        end
    end

endmodule
